// File: rtl/calc_pkg.sv
// Shared encodings and sizes for the stack calculator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   localparam logic [2:0] CMD_PUSH  = 3'd0;
   localparam logic [2:0] CMD_POP   = 3'd1;
   localparam logic [2:0] CMD_ADD   = 3'd2;
   localparam logic [2:0] CMD_SUB   = 3'd3;
   localparam logic [2:0] CMD_TOP   = 3'd4;
   localparam logic [2:0] CMD_CLEAR = 3'd5;
   localparam logic [2:0] CMD_PEEK  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_DONE
   } state_e;

endpackage

// File: rtl/stack_alu.sv
// 8-bit add/subtract of the two top stack entries: y = b + a or b - a (mod 256).
// Latency: combinational.
// Backpressure: none.
module stack_alu (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       sub,
   output logic [7:0] y
);

   // b is the second-from-top entry, a the top; SUB yields second minus top
   assign y = sub ? (b - a) : (b + a);

endmodule

// File: rtl/stack_sequencer.sv
// Sequences stack-calculator commands against a 128x8 sync-read memory.
// Latency: done 1 cycle after accept (err/CLEAR/POP-to-empty), 2 PUSH, 3 POP/TOP/PEEK, 4 ADD/SUB.
// Backpressure: cmd_ready high only in IDLE; cmd_valid is ignored while busy.
module stack_sequencer
   import calc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd,
   input  logic [7:0]        operand,
   output logic              we,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        data_out,
   input  logic [7:0]        data_in,
   output logic              done,
   output logic              err,
   output logic [7:0]        result,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

   state_e            state_q, state_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [7:0]        opnd_q, opnd_d;
   logic [7:0]        a_q, a_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [7:0]        result_q, result_d;
   logic              err_q, err_d;

   logic [CNT_W-1:0]  top_full;
   logic [CNT_W-1:0]  second_full;
   logic [ADDR_W-1:0] top_addr;
   logic [ADDR_W-1:0] second_addr;
   logic [ADDR_W-1:0] push_addr;
   logic [7:0]        alu_y;
   logic              is_empty;
   logic              is_full;

   // Stack grows downward from address 127: top sits at 128 - count
   assign top_full    = DEPTH_C - count_q;
   assign second_full = top_full + ONE_C;
   assign top_addr    = top_full[ADDR_W-1:0];
   assign second_addr = second_full[ADDR_W-1:0];
   assign push_addr   = top_addr - ADDR_W'(1);

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_C);

   stack_alu u_alu (
      .a   (a_q),
      .b   (data_in),
      .sub (cmd_q[0]),
      .y   (alu_y)
   );

   // Next-state, datapath updates and memory-port drive; memory lines idle at 0
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      opnd_d   = opnd_q;
      a_d      = a_q;
      count_d  = count_q;
      result_d = result_q;
      err_d    = err_q;
      we       = 1'b0;
      address  = '0;
      data_out = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_d   = cmd;
               opnd_d  = operand;
               state_d = ST_DONE;
               case (cmd)
                  CMD_PUSH: begin
                     if (is_full) err_d = 1'b1;
                     else         state_d = ST_WR;
                  end
                  CMD_POP: begin
                     if (is_empty) begin
                        err_d = 1'b1;
                     end else if (count_q == ONE_C) begin
                        // Last entry leaves: nothing left to read as the new top
                        count_d  = '0;
                        result_d = '0;
                        err_d    = 1'b0;
                     end else begin
                        state_d = ST_RD0;
                     end
                  end
                  CMD_ADD, CMD_SUB: begin
                     if (count_q < TWO_C) err_d = 1'b1;
                     else                 state_d = ST_RD0;
                  end
                  CMD_TOP: begin
                     if (is_empty) err_d = 1'b1;
                     else          state_d = ST_RD0;
                  end
                  CMD_PEEK: state_d = ST_RD0;
                  CMD_CLEAR: begin
                     count_d  = '0;
                     result_d = '0;
                     err_d    = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_WR: begin
            we       = 1'b1;
            address  = push_addr;
            data_out = opnd_q;
            count_d  = count_q + ONE_C;
            result_d = opnd_q;
            err_d    = 1'b0;
            state_d  = ST_DONE;
         end
         ST_RD0: begin
            // POP reads the entry that becomes the new top
            if (cmd_q == CMD_POP)       address = second_addr;
            else if (cmd_q == CMD_PEEK) address = opnd_q[ADDR_W-1:0];
            else                        address = top_addr;
            state_d = ST_RD1;
         end
         ST_RD1: begin
            if (cmd_q == CMD_ADD || cmd_q == CMD_SUB) begin
               a_d     = data_in;
               address = second_addr;
               state_d = ST_RD2;
            end else begin
               result_d = data_in;
               err_d    = 1'b0;
               if (cmd_q == CMD_POP) count_d = count_q - ONE_C;
               state_d = ST_DONE;
            end
         end
         ST_RD2: begin
            // Result overwrites the second entry, which becomes the new top
            we       = 1'b1;
            address  = second_addr;
            data_out = alu_y;
            result_d = alu_y;
            count_d  = count_q - ONE_C;
            err_d    = 1'b0;
            state_d  = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         opnd_q   <= '0;
         a_q      <= '0;
         count_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         opnd_q   <= opnd_d;
         a_q      <= a_d;
         count_q  <= count_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;
   assign result    = result_q;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized scoreboard bench for stack_sequencer with a queue-based stack model.
// Latency: checks done timing per command class against the accept cycle.
// Backpressure: holds cmd_valid high across busy states to confirm it is ignored.
module tb_stack_sequencer;
   import calc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd = '0;
   logic [7:0] operand = '0;
   logic       cmd_ready, we, done, err, empty, full;
   logic [6:0] address;
   logic [7:0] data_out, data_in, result, count;

   always #5 clk = ~clk;

   stack_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .operand   (operand),
      .we        (we),
      .address   (address),
      .data_out  (data_out),
      .data_in   (data_in),
      .done      (done),
      .err       (err),
      .result    (result),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   // Single-port synchronous-read memory
   logic [7:0] mem [0:127];
   always @(posedge clk) begin
      if (we) mem[address] <= data_out;
      data_in <= mem[address];
   end

   typedef struct {
      logic [7:0] res;
      logic [7:0] cnt;
      logic       er;
      int         lat;
      int         acc;
   } exp_t;

   typedef struct {
      logic [6:0] a;
      logic [7:0] d;
   } wr_t;

   exp_t       exp_q[$];
   wr_t        wr_q[$];
   logic [7:0] stk[$];          // stk[0] is the bottom, stk[$] the top
   logic [7:0] shadow [0:127];  // what memory should hold after predicted writes
   logic [7:0] m_res = '0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         ncyc = 0;
   exp_t       mon_e;
   wr_t        mon_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, ncyc);
      end
   endtask

   // Reference model: apply one accepted command to the abstract stack
   task automatic model_accept(input logic [2:0] c, input logic [7:0] op);
      exp_t       e;
      wr_t        w;
      logic [7:0] a, b, v;
      int         n;
      n     = stk.size();
      e.acc = ncyc;
      e.lat = 1;
      e.er  = 1'b0;
      case (c)
         CMD_PUSH: begin
            if (n == DEPTH) e.er = 1'b1;
            else begin
               stk.push_back(op);
               w.a = 7'(127 - n);
               w.d = op;
               wr_q.push_back(w);
               shadow[w.a] = op;
               m_res = op;
               e.lat = 2;
            end
         end
         CMD_POP: begin
            if (n == 0) e.er = 1'b1;
            else begin
               void'(stk.pop_back());
               m_res = (stk.size() == 0) ? 8'h00 : stk[$];
               e.lat = (n == 1) ? 1 : 3;
            end
         end
         CMD_ADD, CMD_SUB: begin
            if (n < 2) e.er = 1'b1;
            else begin
               a = stk.pop_back();
               b = stk.pop_back();
               v = (c == CMD_SUB) ? b - a : b + a;
               stk.push_back(v);
               w.a = 7'(127 - (n - 2));
               w.d = v;
               wr_q.push_back(w);
               shadow[w.a] = v;
               m_res = v;
               e.lat = 4;
            end
         end
         CMD_TOP: begin
            if (n == 0) e.er = 1'b1;
            else begin
               m_res = stk[$];
               e.lat = 3;
            end
         end
         CMD_PEEK: begin
            m_res = shadow[op[6:0]];
            e.lat = 3;
         end
         CMD_CLEAR: begin
            stk.delete();
            m_res = 8'h00;
         end
         default: e.er = 1'b1;
      endcase
      e.res = m_res;
      e.cnt = 8'(stk.size());
      exp_q.push_back(e);
   endtask

   // Monitor: predicts on acceptance, checks writes and completions
   always @(negedge clk) begin
      ncyc++;
      if (!rst_n) begin
         exp_q.delete();
         wr_q.delete();
         stk.delete();
         m_res = 8'h00;
      end else begin
         if (we) begin
            if (wr_q.size() == 0) chk("unexpected_we", 32'(we), 32'd0);
            else begin
               mon_w = wr_q.pop_front();
               chk("wr_addr", 32'(address), 32'(mon_w.a));
               chk("wr_data", 32'(data_out), 32'(mon_w.d));
            end
         end
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               chk("done_latency", 32'(ncyc - mon_e.acc), 32'(mon_e.lat));
               chk("result", 32'(result), 32'(mon_e.res));
               chk("count", 32'(count), 32'(mon_e.cnt));
               chk("err", 32'(err), 32'(mon_e.er));
               chk("empty", 32'(empty), 32'(mon_e.cnt == 8'd0));
               chk("full", 32'(full), 32'(mon_e.cnt == 8'd128));
            end
         end
         if (cmd_valid && cmd_ready) model_accept(cmd, operand);
      end
   end

   // Present a command and leave it asserted until it is accepted
   task automatic issue(input logic [2:0] c, input logic [7:0] op);
      cmd_valid = 1'b1;
      cmd       = c;
      operand   = op;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      chk("accept", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      cmd_valid = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic random_cmds(input int n);
      int         r;
      logic [2:0] c;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 15));
         if (r <= 5)       c = CMD_PUSH;
         else if (r <= 7)  c = CMD_POP;
         else if (r == 8)  c = CMD_ADD;
         else if (r == 9)  c = CMD_SUB;
         else if (r == 10) c = CMD_TOP;
         else if (r == 11) c = ($urandom_range(0, 3) == 0) ? CMD_CLEAR : CMD_PUSH;
         else if (r <= 13) c = CMD_PEEK;
         else if (r == 14) c = 3'd7;
         else              c = CMD_POP;
         issue(c, 8'($urandom()));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]    = 8'h00;
         shadow[i] = 8'h00;
      end

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // PUSH 5, PUSH 3, SUB -> 2; then ADD wrapping FF + 02
      issue(CMD_PUSH, 8'h05);
      issue(CMD_PUSH, 8'h03);
      issue(CMD_SUB, 8'h00);
      issue(CMD_CLEAR, 8'h00);
      issue(CMD_PUSH, 8'hFF);
      issue(CMD_PUSH, 8'h02);
      issue(CMD_ADD, 8'h00);

      // POP down to empty and beyond
      issue(CMD_CLEAR, 8'h00);
      issue(CMD_PUSH, 8'h05);
      issue(CMD_PUSH, 8'h03);
      issue(CMD_POP, 8'h00);
      issue(CMD_POP, 8'h00);
      issue(CMD_POP, 8'h00);
      drain();

      // Fill completely, overflow, then peek the last-written slot
      issue(CMD_CLEAR, 8'h00);
      for (int i = 0; i < 128; i++) issue(CMD_PUSH, 8'($urandom()));
      issue(CMD_PUSH, 8'hAA);
      issue(CMD_PEEK, 8'h00);
      issue(CMD_PEEK, 8'h7F);
      drain();

      // ADD with one entry is illegal; the next legal command clears err
      issue(CMD_CLEAR, 8'h00);
      issue(CMD_PUSH, 8'h42);
      issue(CMD_ADD, 8'h00);
      issue(CMD_TOP, 8'h00);
      issue(3'd7, 8'h00);
      issue(CMD_CLEAR, 8'h00);
      drain();

      random_cmds(300);
      drain();

      // Reset in RD1 of an ADD while cmd_valid stays high with a new command
      issue(CMD_CLEAR, 8'h00);
      issue(CMD_PUSH, 8'h10);
      issue(CMD_PUSH, 8'h20);
      issue(CMD_ADD, 8'h00);
      cmd_valid = 1'b1;
      cmd       = CMD_PUSH;
      operand   = 8'h77;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);

      random_cmds(60);
      drain();
      chk("writes_all_seen", 32'(wr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
